// File: rtl/sr_reg_bank.sv
// rtl/sr_reg_bank.sv - WIDTH-bit SR/JK/D/T register bank with illegal-SR detection and event counter
module sr_reg_bank #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] illegal,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] illegal_next;
  logic             ev;
  logic             sticky_next;
  logic [CNT_W-1:0] count_next;

  // Per-bit next state for the selected flip-flop mode; en=0 holds q and clears illegal.
  always_comb begin
    q_next       = q;
    illegal_next = '0;
    if (en) begin
      case (mode)
        MODE_SR: begin
          // Set/reset only when a and b differ; S=R=1 holds but is flagged.
          q_next       = (a & ~b) | (q & ~(a ^ b));
          illegal_next = a & b;
        end
        MODE_JK: q_next = (a & ~q) | (~b & q);
        MODE_D:  q_next = a;
        MODE_T:  q_next = q ^ a;
        default: q_next = q;
      endcase
    end
  end

  // Error bookkeeping; an event in the same cycle as clr_err survives the clear.
  always_comb begin
    ev          = |illegal_next;
    sticky_next = err_sticky;
    count_next  = err_count;
    if (en) begin
      if (clr_err) begin
        sticky_next = ev;
        count_next  = ev ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
      end else begin
        sticky_next = err_sticky | ev;
        if (ev && (err_count != CNT_MAX)) begin
          count_next = err_count + 1'b1;
        end
      end
    end
  end

  // State registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      q          <= RESET_VAL;
      illegal    <= '0;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else begin
      q          <= q_next;
      illegal    <= illegal_next;
      err_sticky <= sticky_next;
      err_count  <= count_next;
    end
  end

  assign qbar = ~q;

endmodule

// File: tb/tb_sr_reg_bank.sv
// tb/tb_sr_reg_bank.sv - self-checking bench for sr_reg_bank against a behavioural model
module tb_sr_reg_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] a;
  logic [7:0] b;
  logic       clr_err;
  logic [7:0] q;
  logic [7:0] qbar;
  logic [7:0] illegal;
  logic       err_sticky;
  logic [3:0] err_count;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  logic [7:0] m_q;
  logic [7:0] m_ill;
  logic       m_sticky;
  int         m_cnt;

  sr_reg_bank #(.WIDTH(8), .CNT_W(4), .RESET_VAL(8'h00)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .mode(mode),
    .a(a),
    .b(b),
    .clr_err(clr_err),
    .q(q),
    .qbar(qbar),
    .illegal(illegal),
    .err_sticky(err_sticky),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model written from the per-bit truth tables, one bit at a time.
  task automatic model_edge();
    logic [7:0] nq;
    logic [7:0] nill;
    bit ev;
    nq = m_q;
    nill = 8'h00;
    if (rst) begin
      m_q = 8'h00;
      m_ill = 8'h00;
      m_sticky = 1'b0;
      m_cnt = 0;
      return;
    end
    if (en) begin
      for (int i = 0; i < 8; i++) begin
        if (mode == 2'd0) begin
          if (a[i] && !b[i]) nq[i] = 1'b1;
          else if (!a[i] && b[i]) nq[i] = 1'b0;
          else if (a[i] && b[i]) nill[i] = 1'b1;
        end else if (mode == 2'd1) begin
          if (a[i] && !b[i]) nq[i] = 1'b1;
          else if (!a[i] && b[i]) nq[i] = 1'b0;
          else if (a[i] && b[i]) nq[i] = !m_q[i];
        end else if (mode == 2'd2) begin
          nq[i] = a[i];
        end else begin
          if (a[i]) nq[i] = !m_q[i];
        end
      end
      ev = (nill != 0);
      if (clr_err) begin
        m_cnt = ev ? 1 : 0;
        m_sticky = ev;
      end else begin
        if (ev && m_cnt < 15) m_cnt = m_cnt + 1;
        if (ev) m_sticky = 1'b1;
      end
    end
    m_q = nq;
    m_ill = nill;
  endtask

  task automatic compare_all();
    check("q", {24'd0, q}, {24'd0, m_q});
    check("qbar", {24'd0, qbar}, {24'd0, ~m_q});
    check("illegal", {24'd0, illegal}, {24'd0, m_ill});
    check("err_sticky", {31'd0, err_sticky}, {31'd0, m_sticky});
    check("err_count", {28'd0, err_count}, m_cnt);
  endtask

  task automatic step(input logic r, input logic e, input logic [1:0] md,
                      input logic [7:0] av, input logic [7:0] bv, input logic c);
    rst = r;
    en = e;
    mode = md;
    a = av;
    b = bv;
    clr_err = c;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; a = 8'h00; b = 8'h00; clr_err = 1'b0;
    m_q = 8'h00; m_ill = 8'h00; m_sticky = 1'b0; m_cnt = 0;

    // reset
    step(1, 0, 2'd0, 8'h00, 8'h00, 0);
    check("lit_reset_q", {24'd0, q}, 32'h00);
    check("lit_reset_qbar", {24'd0, qbar}, 32'hFF);

    // SR walk
    step(0, 1, 2'd0, 8'h0F, 8'h00, 0);
    check("lit_sr_set", {24'd0, q}, 32'h0F);
    step(0, 1, 2'd0, 8'h00, 8'h03, 0);
    check("lit_sr_reset", {24'd0, q}, 32'h0C);

    // SR illegal
    step(0, 1, 2'd0, 8'h81, 8'h81, 0);
    check("lit_ill_q", {24'd0, q}, 32'h0C);
    check("lit_ill_bits", {24'd0, illegal}, 32'h81);
    check("lit_ill_cnt", {28'd0, err_count}, 32'd1);
    step(0, 1, 2'd0, 8'h00, 8'h00, 0);
    check("lit_ill_clear", {24'd0, illegal}, 32'h00);

    // JK toggle, then T
    step(0, 1, 2'd1, 8'hFF, 8'hFF, 0);
    check("lit_jk_toggle", {24'd0, q}, 32'hF3);
    step(0, 1, 2'd3, 8'hF0, 8'h00, 0);
    check("lit_t_toggle", {24'd0, q}, 32'h03);

    // D mode and enable gating
    step(0, 1, 2'd2, 8'hA5, 8'h00, 0);
    check("lit_d", {24'd0, q}, 32'hA5);
    step(0, 0, 2'd2, 8'h5A, 8'h00, 0);
    step(0, 0, 2'd0, 8'hFF, 8'hFF, 0);
    check("lit_en_hold_q", {24'd0, q}, 32'hA5);
    check("lit_en_hold_cnt", {28'd0, err_count}, 32'd1);

    // counter saturation
    for (int i = 0; i < 20; i++) step(0, 1, 2'd0, 8'h01, 8'h01, 0);
    check("lit_sat_cnt", {28'd0, err_count}, 32'hF);

    // clear with and without a simultaneous event
    step(0, 1, 2'd0, 8'h10, 8'h10, 1);
    check("lit_clr_ev_cnt", {28'd0, err_count}, 32'd1);
    check("lit_clr_ev_sticky", {31'd0, err_sticky}, 32'd1);
    step(0, 1, 2'd0, 8'h00, 8'h00, 1);
    check("lit_clr_cnt", {28'd0, err_count}, 32'd0);
    check("lit_clr_sticky", {31'd0, err_sticky}, 32'd0);

    // mixed directed vectors checked through the model only
    step(0, 1, 2'd1, 8'h3C, 8'hC3, 0);
    step(0, 1, 2'd3, 8'h55, 8'h00, 0);
    step(0, 1, 2'd0, 8'hAA, 8'h0F, 0);
    step(0, 1, 2'd1, 8'h0F, 8'hF0, 0);

    // build up count=5 with q=3C, then reset mid-operation
    step(0, 1, 2'd2, 8'h3C, 8'h00, 1);
    for (int i = 0; i < 5; i++) step(0, 1, 2'd0, 8'h40, 8'h40, 0);
    check("lit_pre_rst_cnt", {28'd0, err_count}, 32'd5);
    check("lit_pre_rst_q", {24'd0, q}, 32'h3C);
    step(1, 1, 2'd0, 8'hFF, 8'h00, 0);
    check("lit_rst_q", {24'd0, q}, 32'h00);
    check("lit_rst_cnt", {28'd0, err_count}, 32'd0);
    check("lit_rst_sticky", {31'd0, err_sticky}, 32'd0);
    check("lit_rst_ill", {24'd0, illegal}, 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
